// File: rtl/ofmap_accum_controller_pkg.sv
// Shared types and widths for the OFMap accumulation controller.
package ofmap_accum_controller_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 16;
  localparam int WORD_W = LANE_W * LANES;

  // Loop levels from innermost to outermost; also indexes the carry chain.
  typedef enum logic [2:0] {
    LOOP_OW,
    LOOP_OH,
    LOOP_OCT,
    LOOP_ICT,
    LOOP_WW,
    LOOP_WH
  } loop_level_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/ofmap_loop_counter.sv
// One loop level: counts 0..MAX, advancing on carry_in and wrapping to 0
// with carry_out into the next level.
module ofmap_loop_counter
  import ofmap_accum_controller_pkg::*;
#(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic carry_in,
  output logic carry_out
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] cnt;
  logic         at_max;

  assign at_max    = (cnt == W'(MAX));
  assign carry_out = carry_in & at_max;

  // Count register; a start clears it, an accepted step advances or wraps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (carry_in) cnt <= at_max ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/ofmap_accum_controller.sv
// Partial-sum write-back sequencer: first pass writes psums straight into the
// OFMap buffer, later passes do a two-stage read-modify-write.
//
//   state | meaning
//   IDLE  | waiting for start_in
//   RUN   | accepting beats, one per cycle
//   DRAIN | last beat accepted, read/write pipeline emptying
//   DONE  | one-cycle done_out pulse
module ofmap_accum_controller
  import ofmap_accum_controller_pkg::*;
#(
  parameter int MAC_ROW           = 16,
  parameter int MAC_COL           = LANES,
  parameter int OFMAP_BITWIDTH    = LANE_W,
  parameter int OFMAP_ADDR_BIT    = 10,
  parameter int OFMAP_CHANNEL_NUM = 64,
  parameter int IFMAP_CHANNEL_NUM = 32,
  parameter int WEIGHT_WIDTH      = 3,
  parameter int WEIGHT_HEIGHT     = 3,
  parameter int OFMAP_WIDTH       = 14,
  parameter int OFMAP_HEIGHT      = 14
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_in,
  input  logic                                psum_valid_in,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   psum_data_in,
  output logic                                psum_ready_out,
  output logic [OFMAP_ADDR_BIT-1:0]           ofmap_raddr_out,
  output logic                                ofmap_read_en_out,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_rdata_in,
  output logic [OFMAP_ADDR_BIT-1:0]           ofmap_waddr_out,
  output logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ofmap_wdata_out,
  output logic                                ofmap_write_en_out,
  output logic                                busy_out,
  output logic                                done_out
);

  localparam int OCT = OFMAP_CHANNEL_NUM / MAC_COL;
  localparam int ICT = IFMAP_CHANNEL_NUM / MAC_ROW;
  localparam int WW  = MAC_COL * OFMAP_BITWIDTH;

  state_e                    state;
  logic [5:0]                carry;
  logic                      accept;
  logic                      start_go;
  logic                      first_pass;
  logic [OFMAP_ADDR_BIT-1:0] addr;
  logic                      drain_cnt;
  logic                      s1_valid;
  logic                      s1_first;
  logic [WW-1:0]             s1_psum;
  logic                      s2_first;
  logic [WW-1:0]             s2_psum;
  logic [WW-1:0]             lane_sum;

  assign accept   = psum_valid_in & psum_ready_out;
  assign start_go = (state == IDLE) & start_in;

  ofmap_loop_counter #(.MAX(OFMAP_WIDTH - 1)) u_cnt_ow (
    .clk(clk), .rst(rst), .clr(start_go), .carry_in(accept), .carry_out(carry[LOOP_OW]));
  ofmap_loop_counter #(.MAX(OFMAP_HEIGHT - 1)) u_cnt_oh (
    .clk(clk), .rst(rst), .clr(start_go), .carry_in(carry[LOOP_OW]), .carry_out(carry[LOOP_OH]));
  ofmap_loop_counter #(.MAX(OCT - 1)) u_cnt_oct (
    .clk(clk), .rst(rst), .clr(start_go), .carry_in(carry[LOOP_OH]), .carry_out(carry[LOOP_OCT]));
  ofmap_loop_counter #(.MAX(ICT - 1)) u_cnt_ict (
    .clk(clk), .rst(rst), .clr(start_go), .carry_in(carry[LOOP_OCT]), .carry_out(carry[LOOP_ICT]));
  ofmap_loop_counter #(.MAX(WEIGHT_WIDTH - 1)) u_cnt_ww (
    .clk(clk), .rst(rst), .clr(start_go), .carry_in(carry[LOOP_ICT]), .carry_out(carry[LOOP_WW]));
  ofmap_loop_counter #(.MAX(WEIGHT_HEIGHT - 1)) u_cnt_wh (
    .clk(clk), .rst(rst), .clr(start_go), .carry_in(carry[LOOP_WW]), .carry_out(carry[LOOP_WH]));

  // Sequencer: state, handshake/status outputs, running address and pass flag.
  // Address is linear over (oct, pixel), so it simply wraps with the oct carry;
  // the first pass ends exactly when that carry first fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      psum_ready_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      addr           <= '0;
      first_pass     <= 1'b0;
      drain_cnt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            state          <= RUN;
            psum_ready_out <= 1'b1;
            busy_out       <= 1'b1;
            addr           <= '0;
            first_pass     <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            addr <= carry[LOOP_OCT] ? '0 : addr + OFMAP_ADDR_BIT'(1);
            if (carry[LOOP_OCT]) first_pass <= 1'b0;
            if (carry[LOOP_WH]) begin
              state          <= DRAIN;
              psum_ready_out <= 1'b0;
              drain_cnt      <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 1'b0) begin
            state    <= DONE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else begin
            drain_cnt <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          done_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage RMW pipeline: stage 1 issues the read, stage 2 writes the sum
  // once the buffer's read data has arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofmap_read_en_out  <= 1'b0;
      ofmap_raddr_out    <= '0;
      s1_valid           <= 1'b0;
      s1_first           <= 1'b0;
      s1_psum            <= '0;
      ofmap_write_en_out <= 1'b0;
      ofmap_waddr_out    <= '0;
      s2_first           <= 1'b0;
      s2_psum            <= '0;
    end else begin
      ofmap_read_en_out  <= accept & ~first_pass;
      s1_valid           <= accept;
      if (accept) begin
        ofmap_raddr_out <= addr;
        s1_first        <= first_pass;
        s1_psum         <= psum_data_in;
      end
      ofmap_write_en_out <= s1_valid;
      if (s1_valid) begin
        ofmap_waddr_out <= ofmap_raddr_out;
        s2_first        <= s1_first;
        s2_psum         <= s1_psum;
      end
    end
  end

  // Independent per-lane adders; each wraps within its own lane.
  for (genvar i = 0; i < MAC_COL; i++) begin : g_lane
    assign lane_sum[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] =
      ofmap_rdata_in[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] + s2_psum[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH];
  end

  // Write data is only driven while the write strobe is up so idle/reset shows 0.
  always_comb begin
    ofmap_wdata_out = '0;
    if (ofmap_write_en_out) ofmap_wdata_out = s2_first ? s2_psum : lane_sum;
  end

endmodule

// File: doc/ofmap_accum_controller.md
# ofmap_accum_controller

Sequences partial-sum write-back from the MAC array into the OFMap buffer across all convolution passes. The first pass writes each output word directly; every later pass performs a pipelined read-modify-write. It sits beside the IFMap/weight read controller, consumes the MAC array's column outputs, and drives the dual-port OFMap buffer. Loop order matches the read side, from innermost to outermost:
- output pixel (O_W, then O_H);
- output-channel tile;
- input-channel tile;
- W_W;
- W_H.

## Interface
- MAC_ROW, 16, array rows; sets input-channel tile size
- MAC_COL, 16, array columns (lanes per word)
- OFMAP_BITWIDTH, 32, lane width
- OFMAP_ADDR_BIT, 10, OFMap buffer address width
- OFMAP_CHANNEL_NUM, 64, output channels
- IFMAP_CHANNEL_NUM, 32, input channels
- WEIGHT_WIDTH, 3, kernel width
- WEIGHT_HEIGHT, 3, kernel height
- OFMAP_WIDTH, 14, output width
- OFMAP_HEIGHT, 14, output height

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_in  in  1  one-cycle start pulse
- psum_valid_in  in  1  psum_data_in holds one output pixel's MAC_COL lanes
- psum_data_in  in  MAC_COL*OFMAP_BITWIDTH  partial sums, lane 0 in LSBs
- psum_ready_out  out  1  high only in RUN
- ofmap_raddr_out  out  OFMAP_ADDR_BIT  read address
- ofmap_read_en_out  out  1  read strobe
- ofmap_rdata_in  in  MAC_COL*OFMAP_BITWIDTH  read data, 1-cycle latency after read_en
- ofmap_waddr_out  out  OFMAP_ADDR_BIT  write address
- ofmap_wdata_out  out  MAC_COL*OFMAP_BITWIDTH  write data
- ofmap_write_en_out  out  1  write strobe
- busy_out  out  1  high in RUN and DRAIN
- done_out  out  1  one-cycle pulse after the final write

## Operation
- Derived constants:
  - PIX = OFMAP_WIDTH*OFMAP_HEIGHT
  - OCT = OFMAP_CHANNEL_NUM/MAC_COL
  - ICT = IFMAP_CHANNEL_NUM/MAC_ROW
  - PASSES = ICT*WEIGHT_WIDTH*WEIGHT_HEIGHT
  - Legal configurations require OCT*PIX ≥ 3 and OCT*PIX ≤ 2^OFMAP_ADDR_BIT.
- Nested counters: ow, oh, oct, ict, ww, wh.
  - All advance by one step per accepted beat (psum_valid_in & psum_ready_out).
  - Each counter wraps at its own maximum and carries into the next loop level.
- Address = oct*PIX + oh*OFMAP_WIDTH + ow, computed as a running counter with no multiplier. It resets to 0 when oct wraps.
- first_pass = (ict==0 && ww==0 && wh==0).
- States and transitions:
  - IDLE → RUN on start_in; counters cleared.
  - RUN → DRAIN when the last beat is accepted (all counters at max).
  - DRAIN → DONE after 2 cycles, when the pipeline is empty.
  - DONE → IDLE after 1 cycle; done_out=1 in that cycle.
- start_in is ignored outside IDLE.
- psum_valid_in while psum_ready_out=0 is ignored, not lost: the producer holds it.
- Arithmetic:
  - Lane-wise add, wdata[i] = rdata[i] + psum[i].
  - Wraps modulo 2^OFMAP_BITWIDTH; no saturation and no cross-lane carry.
  - On first_pass, wdata = psum unmodified.
- Reset, including mid-operation:
  - State returns to IDLE; all counters and pipeline registers go to 0.
  - All outputs go to 0. Pending writes are discarded.

## Timing
- Beat accepted in cycle T:
  - T+1: ofmap_read_en_out = ~first_pass, ofmap_raddr_out = address.
  - T+2: ofmap_write_en_out = 1, ofmap_waddr_out = same address, ofmap_wdata_out = sum.
- Throughput is one beat per cycle; RUN never deasserts ready.
- Hazards:
  - Read and write of the same address are ≥ OCT*PIX beats apart, so no forwarding is needed (hence the legal-config bound OCT*PIX ≥ 3).
  - Simultaneous read and write of different addresses in one cycle are legal on the dual-port buffer.
- Stalls: with psum_valid_in low, bubbles propagate and strobes are low in the matching cycles.
- done_out fires 3 cycles after the last accept, one cycle after the final write.

## Structure
- Shared package:
  - Loop-order enum.
  - State enum: IDLE, RUN, DRAIN, DONE.
  - Lane-width and word-width localparams.
- One sub-module, ofmap_loop_counter: a parameterised wrap counter with carry-in and carry-out, instanced six times.
- Lane adder: generate loop in the top module.

## Test plan
- Reset mid-RUN after 100 beats:
  - All outputs go to 0 and state returns to IDLE.
  - A new start_in then restarts at address 0 with a first-pass write.
- Default config, all psum lanes = 1, continuous valid: 14112 beats accepted.
  - First 784 writes carry lane value 1 with read_en low.
  - The final buffer model holds 18 in every lane of all 784 words.
  - done_out pulses once, 3 cycles after the last accept.
- Address sequence check, write side:
  - Writes go to addresses 0..783 in order, every pass.
  - Address 196 begins oct=1.
- Random valid gaps of 0–5 cycles:
  - The final buffer contents equal the reference sum.
  - Strobes fire only 1 and 2 cycles after accepts.
- Wrap arithmetic, lanes = 0xFFFFFFFF over 2 passes: the result lane is 0xFFFFFFFE with no corruption of adjacent lanes.
- start_in pulsed during RUN and DRAIN: ignored; exactly one done_out pulse.
